// File: rtl/stepper_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : stepper_phase_gen
// Purpose  : Ramped stepper coil phase generator (full/half step).
// Revision : 1.0 - initial release
// ============================================================================
module stepper_phase_gen #(
  parameter int BASE_DIV   = 250000,
  parameter int DIV_STEP   = 15000,
  parameter int RAMP_STEPS = 8,
  parameter int HALF_STEP  = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       startsig,
  input  logic       directsig,
  input  logic [3:0] speed,
  output logic [3:0] stepmotor,
  output logic       running,
  output logic       step_pulse,
  output logic [3:0] cur_speed
);

  localparam int CW = $clog2(BASE_DIV + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DECEL   = 2'd2,
    S_REVERSE = 2'd3
  } state_t;

  state_t          r_state;
  logic [2:0]      r_phase;
  logic            r_dir;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_ramp;

  logic [CW-1:0]   w_period;
  logic            w_boundary;
  logic [2:0]      w_phase_adv;
  logic [3:0]      w_target;
  logic [3:0]      w_speed_nxt;
  logic [7:0]      w_ramp_nxt;

  function automatic logic [3:0] f_pattern(input logic [2:0] idx);
    logic [3:0] pat;
    pat = 4'b0000;
    if (HALF_STEP != 0) begin
      case (idx)
        3'd0:    pat = 4'b0001;
        3'd1:    pat = 4'b0011;
        3'd2:    pat = 4'b0010;
        3'd3:    pat = 4'b0110;
        3'd4:    pat = 4'b0100;
        3'd5:    pat = 4'b1100;
        3'd6:    pat = 4'b1000;
        default: pat = 4'b1001;
      endcase
    end else begin
      case (idx[1:0])
        2'd0:    pat = 4'b0011;
        2'd1:    pat = 4'b0110;
        2'd2:    pat = 4'b1100;
        default: pat = 4'b1001;
      endcase
    end
    return pat;
  endfunction

  // Period is recomputed every cycle; >= lets a shortened period fire at once.
  assign w_period   = CW'(BASE_DIV - int'(cur_speed) * DIV_STEP);
  assign w_boundary = (r_cnt >= (w_period - CW'(1)));
  assign w_target   = (r_state == S_RUN) ? speed : 4'd0;
  assign running    = (r_state != S_IDLE);

  always_comb begin
    w_phase_adv = r_dir ? (r_phase + 3'd1) : (r_phase - 3'd1);
    if (HALF_STEP == 0) begin
      w_phase_adv[2] = 1'b0;
    end
  end

  always_comb begin
    w_speed_nxt = cur_speed;
    w_ramp_nxt  = 8'd0;
    if (cur_speed != w_target) begin
      if (r_ramp == 8'(RAMP_STEPS - 1)) begin
        w_speed_nxt = (w_target > cur_speed) ? (cur_speed + 4'd1) : (cur_speed - 4'd1);
      end else begin
        w_ramp_nxt = r_ramp + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_phase    <= 3'd0;
      r_dir      <= 1'b0;
      r_cnt      <= '0;
      r_ramp     <= 8'd0;
      stepmotor  <= 4'b0000;
      step_pulse <= 1'b0;
      cur_speed  <= 4'd0;
    end else begin
      step_pulse <= 1'b0;
      if (r_state == S_IDLE) begin
        r_cnt     <= '0;
        r_ramp    <= 8'd0;
        cur_speed <= 4'd0;
        stepmotor <= startsig ? f_pattern(r_phase) : 4'b0000;
        if (startsig) begin
          r_dir   <= directsig;
          r_state <= S_RUN;
        end
      end else begin
        if (w_boundary) begin
          r_cnt      <= '0;
          r_phase    <= w_phase_adv;
          step_pulse <= 1'b1;
          cur_speed  <= w_speed_nxt;
          r_ramp     <= w_ramp_nxt;
          stepmotor  <= f_pattern(w_phase_adv);
        end else begin
          r_cnt     <= r_cnt + CW'(1);
          stepmotor <= f_pattern(r_phase);
        end

        case (r_state)
          S_RUN: begin
            if (!startsig) begin
              r_state <= S_DECEL;
            end else if (directsig != r_dir) begin
              r_state <= S_REVERSE;
            end
          end
          S_DECEL: begin
            if (startsig) begin
              r_state <= S_RUN;
            end else if (w_boundary && (w_speed_nxt == 4'd0)) begin
              r_state   <= S_IDLE;
              stepmotor <= 4'b0000;
            end
          end
          S_REVERSE: begin
            if (!startsig) begin
              r_state <= S_DECEL;
            end else if (w_boundary && (w_speed_nxt == 4'd0)) begin
              r_dir   <= ~r_dir;
              r_state <= S_RUN;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
